// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - MIPS-subset decode/operand fetch feeding the ALU through one registered slot
module decode_issue_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_input1,
    output logic [DATA_W-1:0] out_input2,
    output logic [1:0]        out_aluOp,
    output logic [5:0]        out_funct,
    output logic [4:0]        out_dest,
    output logic              out_illegal,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  issue_count,
    output logic [CNT_W-1:0]  illegal_count
);

    logic [REG_COUNT-1:0][DATA_W-1:0] regs;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    logic [DATA_W-1:0] d_in1;
    logic [DATA_W-1:0] d_in2;
    logic [1:0]        d_op;
    logic [5:0]        d_fn;
    logic [4:0]        d_dst;
    logic              d_ill;

    logic accept;
    logic consume;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign shamt  = in_instr[10:6];
    assign funct  = in_instr[5:0];
    assign imm    = in_instr[15:0];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // A writeback landing on the same edge as acceptance is forwarded so the slot sees the new value
    assign rs_val = (rs == 5'd0) ? '0 : ((wb_en && wb_addr == rs) ? wb_data : regs[rs]);
    assign rt_val = (rt == 5'd0) ? '0 : ((wb_en && wb_addr == rt) ? wb_data : regs[rt]);

    always_comb begin
        d_in1 = '0;
        d_in2 = '0;
        d_op  = 2'd0;
        d_fn  = 6'd0;
        d_dst = 5'd0;
        d_ill = 1'b0;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd0, 6'd2, 6'd3: begin
                        d_op  = 2'd2;
                        d_fn  = funct;
                        d_dst = rd;
                        d_in1 = {{(DATA_W-5){1'b0}}, shamt};
                        d_in2 = rt_val;
                    end
                    6'd32, 6'd34, 6'd36, 6'd37, 6'd42: begin
                        d_op  = 2'd2;
                        d_fn  = funct;
                        d_dst = rd;
                        d_in1 = rs_val;
                        d_in2 = rt_val;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            6'd8: begin
                d_op  = 2'd0;
                d_dst = rt;
                d_in1 = rs_val;
                d_in2 = {{(DATA_W-16){imm[15]}}, imm};
            end
            6'd12: begin
                d_op  = 2'd1;
                d_dst = rt;
                d_in1 = rs_val;
                d_in2 = {{(DATA_W-16){1'b0}}, imm};
            end
            default: d_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operands are captured at acceptance; later writebacks never disturb a held slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_input1  <= '0;
            out_input2  <= '0;
            out_aluOp   <= 2'd0;
            out_funct   <= 6'd0;
            out_dest    <= 5'd0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_input1  <= d_in1;
            out_input2  <= d_in2;
            out_aluOp   <= d_op;
            out_funct   <= d_fn;
            out_dest    <= d_dst;
            out_illegal <= d_ill;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count   <= '0;
            illegal_count <= '0;
        end else begin
            if (consume) begin
                issue_count <= issue_count + 1'b1;
            end
            if (accept && d_ill) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - scoreboard bench for decode_issue_stage
module tb_decode_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_input1;
    logic [31:0] out_input2;
    logic [1:0]  out_aluOp;
    logic [5:0]  out_funct;
    logic [4:0]  out_dest;
    logic        out_illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [15:0] issue_count;
    logic [15:0] illegal_count;

    decode_issue_stage #(.DATA_W(32), .REG_COUNT(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_input1(out_input1), .out_input2(out_input2),
        .out_aluOp(out_aluOp), .out_funct(out_funct), .out_dest(out_dest),
        .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_count(issue_count), .illegal_count(illegal_count)
    );

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [4:0]  dst;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mregs [32];
    logic [15:0] exp_issue;
    logic [15:0] exp_illegal;
    int          n_cmp;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [31:0] a;
        logic [31:0] b;
        e = '0;
        a = rd_model(ins[25:21]);
        b = rd_model(ins[20:16]);
        case (ins[31:26])
            6'd0: begin
                e.op = 2'd2; e.fn = ins[5:0]; e.dst = ins[15:11];
                if (ins[5:0] == 6'd0 || ins[5:0] == 6'd2 || ins[5:0] == 6'd3) begin
                    e.in1 = {27'd0, ins[10:6]}; e.in2 = b;
                end else if (ins[5:0] == 6'd32 || ins[5:0] == 6'd34 || ins[5:0] == 6'd36 ||
                             ins[5:0] == 6'd37 || ins[5:0] == 6'd42) begin
                    e.in1 = a; e.in2 = b;
                end else begin
                    e = '0; e.ill = 1'b1;
                end
            end
            6'd8:  begin e.op = 2'd0; e.dst = ins[20:16]; e.in1 = a; e.in2 = {{16{ins[15]}}, ins[15:0]}; end
            6'd12: begin e.op = 2'd1; e.dst = ins[20:16]; e.in1 = a; e.in2 = {16'd0, ins[15:0]}; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Every held cycle is compared against the head entry, so slot stability is covered too
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb[0];
                    check_val("mon_in1", out_input1, mon_e.in1);
                    check_val("mon_in2", out_input2, mon_e.in2);
                    check_val("mon_op", 32'(out_aluOp), 32'(mon_e.op));
                    check_val("mon_fn", 32'(out_funct), 32'(mon_e.fn));
                    check_val("mon_dst", 32'(out_dest), 32'(mon_e.dst));
                    check_val("mon_ill", 32'(out_illegal), 32'(mon_e.ill));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        exp_issue++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e = model(in_instr);
                sb.push_back(mon_e);
                if (mon_e.ill) exp_illegal++;
            end
            if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_chk(input string tag, input logic [31:0] ins, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [1:0] eop, input logic [5:0] efn,
                             input logic [4:0] edst, input logic eill);
        in_valid = 1'b1;
        in_instr = ins;
        cyc();
        in_valid = 1'b0;
        wb_en    = 1'b0;
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_in1"}, out_input1, e1);
        check_val({tag, "_in2"}, out_input2, e2);
        check_val({tag, "_op"}, 32'(out_aluOp), 32'(eop));
        check_val({tag, "_fn"}, 32'(out_funct), 32'(efn));
        check_val({tag, "_dst"}, 32'(out_dest), 32'(edst));
        check_val({tag, "_ill"}, 32'(out_illegal), 32'(eill));
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        exp_issue   = 16'd0;
        exp_illegal = 16'd0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        n_cmp = 0;
        n_bad = 0;
        model_clear();
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        cyc(); cyc();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_in1", out_input1, 32'd0);
        check_val("rst_dest", 32'(out_dest), 32'd0);
        check_val("rst_issue", 32'(issue_count), 32'd0);
        check_val("rst_illegal", 32'(illegal_count), 32'd0);
        rst = 1'b0;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; cyc();
        wb_addr = 5'd2; wb_data = 32'd7; cyc();
        wb_en = 1'b0;

        issue_chk("add",  32'h00221820, 32'd5, 32'd7, 2'd2, 6'd32, 5'd3, 1'b0);
        issue_chk("addi", 32'h2024FFFF, 32'd5, 32'hFFFFFFFF, 2'd0, 6'd0, 5'd4, 1'b0);
        issue_chk("andi", 32'h30248000, 32'd5, 32'h00008000, 2'd1, 6'd0, 5'd4, 1'b0);
        issue_chk("sll",  32'h000228C0, 32'd3, 32'd7, 2'd2, 6'd0, 5'd5, 1'b0);
        cyc();

        // Stall with a pending instruction, writeback during hold, then consume+refill
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820;
        cyc();
        in_instr = 32'h2024FFFF;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            check_val("stall_in_ready", 32'(in_ready), 32'd0);
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_in1", out_input1, 32'd5);
            check_val("stall_in2", out_input2, 32'd7);
            check_val("stall_dst", 32'(out_dest), 32'd3);
            cyc();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check_val("refill_valid", 32'(out_valid), 32'd1);
        check_val("refill_dst", 32'(out_dest), 32'd4);
        check_val("refill_in1", out_input1, 32'h99);
        check_val("refill_in2", out_input2, 32'hFFFFFFFF);
        check_val("refill_issue", 32'(issue_count), 32'(exp_issue));
        cyc();
        check_val("drain_valid", 32'(out_valid), 32'd0);
        check_val("drain_issue", 32'(issue_count), 32'(exp_issue));

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
        issue_chk("bypass", 32'h00221820, 32'h1234, 32'd7, 2'd2, 6'd32, 5'd3, 1'b0);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd9; cyc();
        wb_en = 1'b0;
        issue_chk("r0", 32'h00021820, 32'd0, 32'd7, 2'd2, 6'd32, 5'd3, 1'b0);

        issue_chk("lw", 32'h8C220000, 32'd0, 32'd0, 2'd0, 6'd0, 5'd0, 1'b1);
        check_val("lw_illcnt", 32'(illegal_count), 32'd1);
        issue_chk("addu", 32'h00221821, 32'd0, 32'd0, 2'd0, 6'd0, 5'd0, 1'b1);
        check_val("addu_illcnt", 32'(illegal_count), 32'd2);
        cyc();

        for (int c = 0; c < 300; c++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 8))
                0: fn = 6'd0;  1: fn = 6'd2;  2: fn = 6'd3;  3: fn = 6'd32;
                4: fn = 6'd34; 5: fn = 6'd36; 6: fn = 6'd37; 7: fn = 6'd42;
                default: fn = 6'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: ins = {6'd0, rs, rt, rd, 5'($urandom), fn};
                1: ins = {6'd8, rs, rt, 16'($urandom)};
                2: ins = {6'd12, rs, rt, 16'($urandom)};
                default: ins = {6'($urandom), rs, rt, 16'($urandom)};
            endcase
            in_instr  = ins;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            cyc();
        end
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        check_val("rand_sb_empty", sb.size(), 32'd0);
        check_val("rand_issue", 32'(issue_count), 32'(exp_issue));
        check_val("rand_illegal", 32'(illegal_count), 32'(exp_illegal));

        // Asynchronous reset while the slot is occupied
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820;
        cyc();
        in_valid = 1'b0;
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_in1", out_input1, 32'd0);
        check_val("mid_rst_issue", 32'(issue_count), 32'd0);
        check_val("mid_rst_illegal", 32'(illegal_count), 32'd0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        issue_chk("post_rst", 32'h00221820, 32'd0, 32'd0, 2'd2, 6'd32, 5'd3, 1'b0);
        cyc();
        check_val("end_sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 32-bit MIPS-subset ALU.
- Accepts raw 32-bit instructions and reads a 32x32 register file, which is written back from downstream.
- Produces ALU operands input1/input2 plus aluOp/funct and the destination register.
- Output is one registered pipeline slot with a valid/ready handshake on both sides.

Parameters:
- DATA_W, 32, operand/register width
- REG_COUNT, 32, number of architectural registers (index width 5)
- CNT_W, 16, width of the issue and illegal counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction present
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  32  MIPS instruction word
- out_valid  output  1  decoded slot holds a valid operation
- out_ready  input  1  ALU/execute stage consumes the slot this cycle
- out_input1  output  32  ALU input1 (rs value, or zero-extended shamt for shifts)
- out_input2  output  32  ALU input2 (rt value or extended immediate)
- out_aluOp  output  2  0=add (addi), 1=and (andi), 2=R-type
- out_funct  output  6  R-type funct field; 0 when aluOp is not 2
- out_dest  output  5  destination register; 0 means no write
- out_illegal  output  1  unsupported opcode/funct
- wb_en  input  1  writeback strobe
- wb_addr  input  5  writeback register
- wb_data  input  32  writeback value
- issue_count  output  CNT_W  instructions handed to the ALU
- illegal_count  output  CNT_W  illegal instructions accepted

Behaviour:
- Reset (async, immediate):
  - out_valid=0; all out_* fields=0.
  - Both counters=0.
  - All registers=0.
  - in_ready=1 after reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. Decoded fields are registered on that edge; latency is 1 cycle.
  - out_valid stays 1 with all fields stable until out_ready=1.
  - Simultaneous consume and accept refills the slot in the same edge, so there is no bubble.
- Decode: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0], imm = [15:0].
  - opcode 0:
    - aluOp=2, funct=instr funct, dest=rd.
    - funct 0/2/3 (sll/srl/sra): input1={27'b0,shamt}, input2=R[rt].
    - funct 32/34/36/37/42: input1=R[rs], input2=R[rt].
    - Any other funct: illegal.
  - opcode 8 (addi): aluOp=0, input1=R[rs], input2=sign-extended imm, dest=rt.
  - opcode 12 (andi): aluOp=1, input1=R[rs], input2=zero-extended imm, dest=rt.
  - Any other opcode: illegal.
  - Illegal instructions are still passed down: out_illegal=1, dest=0, aluOp=0, funct=0, operands=0.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - Write occurs on a clk edge when wb_en=1.
  - Write-read bypass: if wb_en && wb_addr!=0 && wb_addr matches rs/rt in the accept cycle, wb_data is used as the operand.
  - Operands are snapshotted at acceptance. Writebacks while the slot is held do not alter out_input1/out_input2.
  - There is no hazard interlock; dependent instructions are scheduled by software.
- Counters:
  - issue_count increments on out_valid && out_ready.
  - illegal_count increments on acceptance of an illegal instruction.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation: an in-flight slot is discarded and the register file is cleared. No partial writeback completes.

Test Plan:
- Reset, then writeback R1=5, R2=7. Accept add $3,$1,$2 (0x00221820) -> next cycle out_valid=1, input1=5, input2=7, aluOp=2, funct=32, dest=3.
- addi $4,$1,-1 (0x2024FFFF) -> input1=5, input2=0xFFFFFFFF, aluOp=0, dest=4. andi $4,$1,0x8000 (0x30248000) -> input2=0x00008000, aluOp=1.
- sll $5,$2,3 (0x000228C0) -> input1=3, input2=7, funct=0, dest=5.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 with a new instruction -> slot refills the same edge, and issue_count increments by 1 per consume.
- Same-cycle wb_en R1=0x1234 while accepting add $3,$1,$2 -> input1=0x1234. Writeback to R0 with value 9 -> later read of rs=0 gives 0.
- Opcode 0x23 (lw) -> out_illegal=1, dest=0, illegal_count=1. Assert rst while out_valid=1 -> out_valid drops immediately and registers read 0.
